// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder.
//   state_t       - FSM state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH - default operand/sum width in bits
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_addbit.sv
// addbit: single-bit full adder cell, purely combinational.
//   cin  - carry in
//   a, b - operand bits
//   cout - carry out
//   sum  - sum bit
module addbit (
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic cout,
  output logic sum
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder processed LSB-first, one bit per clock,
// through a single addbit cell with a registered carry.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, accepted in IDLE or DONE
//   a, b  - operands, captured on accepted start
//   cin   - carry in, captured on accepted start
//   busy  - high while bits are being processed
//   done  - one-cycle strobe when sum/cout update
//   sum   - last completed result (held)
//   cout  - carry out of last completed result (held)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_cout;

  // The only arithmetic: current LSBs plus the registered carry.
  addbit u_addbit (
    .cin  (carry),
    .a    (reg_a[0]),
    .b    (reg_b[0]),
    .cout (bit_cout),
    .sum  (bit_sum)
  );

  // FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            reg_a <= a;
            reg_b <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so bit 0 lands at res[0] after WIDTH shifts.
          reg_a <= reg_a >> 1;
          reg_b <= reg_b >> 1;
          res   <= {bit_sum, res[WIDTH-1:1]};
          carry <= bit_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {bit_sum, res[WIDTH-1:1]};
            cout  <= bit_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W:0]  res;
    int unsigned at;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [W:0]  last_res = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop on each done, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (rst) begin
      last_res = '0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("result", 32'({cout, sum}), 32'(e.res));
          last_res = e.res;
        end
      end else begin
        chk("hold", 32'({cout, sum}), 32'(last_res));
      end
      if (sb.size() > 0 && cyc > sb[0].at) begin
        chk("missing_done", 32'(cyc), 32'(sb[0].at));
        void'(sb.pop_front());
      end
    end
  end

  // Present an operation at the current negedge for exactly one edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, output int unsigned at);
    exp_t e;
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    e.res = (W+1)'(ia) + (W+1)'(ib) + (W+1)'(ic);
    e.at  = cyc + 1 + W;
    at    = e.at;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic wait_until(input int unsigned at);
    while (cyc < at) @(negedge clk);
  endtask

  initial begin
    int unsigned at;
    int unsigned gap;

    // Reset with random inputs and start asserted.
    rst   = 1'b1;
    start = 1'b1;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_sum",  32'(sum),  32'(0));
      chk("rst_cout", 32'(cout), 32'(0));
    end
    start = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Basic and carry ripple.
    issue(8'h5A, 8'h33, 1'b0, at);
    chk("busy_during_shift", 32'(busy), 32'(1));
    wait_until(at);
    chk("busy_in_done", 32'(busy), 32'(0));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
    issue(8'hFF, 8'h01, 1'b0, at);
    wait_until(at);
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b1, at);
    wait_until(at);
    @(negedge clk);

    // start during SHIFT is ignored; start held in DONE chains the next op.
    issue(8'h5A, 8'h33, 1'b0, at);
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(at);
    issue(8'h80, 8'h80, 1'b0, at);
    wait_until(at);
    @(negedge clk);

    // Abort mid-operation: outputs clear immediately, no done follows.
    issue(8'h0F, 8'h01, 1'b0, at);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum",  32'(sum),  32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    issue(8'h0F, 8'h01, 1'b1, at);
    wait_until(at);
    @(negedge clk);

    // Random operations; gap 0 means start asserted in the DONE cycle.
    for (int i = 0; i < 500; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), at);
      wait_until(at);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    repeat (W + 3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
